data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 175 +++++++++++++++++
 tb/tb_data_mem_responder.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder: single-port 64-bit data memory behind a request/response
// handshake. It holds at most one access at a time: accept in IDLE, count
// WAIT_STATES cycles in WAIT, present the response in RESP until the core takes it.
//
// Handshake: a request transfers on a rising CLK edge where req_valid && req_ready.
// A response transfers on a rising edge where rsp_valid && rsp_ready. While
// rsp_valid is high, rsp_rdata and rsp_err do not change.
//
// Optional feature: define DMEM_MISALIGN_ERR_EN to fault misaligned accesses
// (rsp_err=1, rsp_rdata=0, no store). Otherwise the low address bits are
// truncated to the access size and rsp_err is always 0.
module data_mem_responder #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err,
  output logic [1:0]  dbg_state
);

  localparam int AW = DEPTH_LOG2 + 3;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        rdy_q;
  logic        accept, enter_resp;

  logic        lat_we;
  logic [1:0]  lat_size;
  logic [AW-1:0] lat_addr;
  logic [63:0] lat_wdata;
  logic [63:0] rsp_rdata_q;
  logic        rsp_err_q;

  logic        cur_we;
  logic [1:0]  cur_size;
  logic [AW-1:0] cur_addr;
  logic [63:0] cur_wdata;
  logic [2:0]  align_mask, off;
  logic        misalign, fault, commit;
  logic [DEPTH_LOG2-1:0] idx;
  logic [7:0]  lane_base, lane_mask;
  logic [63:0] bit_mask, size_mask, wdata_sh, load_data;
  logic [5:0]  shamt;

  logic [63:0] mem [0:(1<<DEPTH_LOG2)-1];

  // Address bits above the storage range are ignored, so addresses alias.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[63:AW];

  assign req_ready = (state_q == IDLE) && rdy_q;
  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign dbg_state = state_q;

  // State register, wait counter and the post-reset ready enable.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdy_q   <= 1'b1;
    end
  end

  // Next-state logic: accept in IDLE, count down in WAIT, drain in RESP.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    accept     = 1'b0;
    enter_resp = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid && rdy_q) begin
          accept = 1'b1;
          if (WAIT_STATES == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
            cnt_d      = 4'd0;
          end else begin
            state_d = WAIT;
            cnt_d   = WAIT_INIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Decode the access in flight; with no wait states it is still on the inputs.
  always_comb begin
    cur_we    = (state_q == IDLE) ? req_we    : lat_we;
    cur_size  = (state_q == IDLE) ? req_size  : lat_size;
    cur_addr  = (state_q == IDLE) ? req_addr[AW-1:0] : lat_addr;
    cur_wdata = (state_q == IDLE) ? req_wdata : lat_wdata;
    case (cur_size)
      2'd0:    begin align_mask = 3'b000; lane_base = 8'h01; size_mask = 64'h0000_0000_0000_00ff; end
      2'd1:    begin align_mask = 3'b001; lane_base = 8'h03; size_mask = 64'h0000_0000_0000_ffff; end
      2'd2:    begin align_mask = 3'b011; lane_base = 8'h0f; size_mask = 64'h0000_0000_ffff_ffff; end
      default: begin align_mask = 3'b111; lane_base = 8'hff; size_mask = 64'hffff_ffff_ffff_ffff; end
    endcase
    misalign = |(cur_addr[2:0] & align_mask);
`ifdef DMEM_MISALIGN_ERR_EN
    fault = misalign;
`else
    fault = 1'b0;
`endif
    off       = cur_addr[2:0] & ~align_mask;
    idx       = cur_addr[AW-1:3];
    lane_mask = lane_base << off;
    bit_mask  = '0;
    for (int i = 0; i < 8; i++) bit_mask[8*i +: 8] = {8{lane_mask[i]}};
    shamt     = {off, 3'b000};
    wdata_sh  = cur_wdata << shamt;
    load_data = (mem[idx] >> shamt) & size_mask;
    commit    = enter_resp && cur_we && !fault;
  end

  // Storage: lane-masked store on the edge entering RESP; contents survive reset.
  always_ff @(posedge CLK) begin
    if (commit && !RESET) mem[idx] <= (mem[idx] & ~bit_mask) | (wdata_sh & bit_mask);
  end

  // Request latch and response registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      lat_we      <= 1'b0;
      lat_size    <= 2'd0;
      lat_addr    <= '0;
      lat_wdata   <= 64'd0;
      rsp_rdata_q <= 64'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      if (accept) begin
        lat_we    <= req_we;
        lat_size  <= req_size;
        lat_addr  <= req_addr[AW-1:0];
        lat_wdata <= req_wdata;
      end
      if (enter_resp) begin
        rsp_rdata_q <= (cur_we || fault) ? 64'd0 : load_data;
        rsp_err_q   <= fault;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: randomized and directed accesses checked against a
// byte-addressed reference memory. Built with WAIT_STATES=3; honours
// DMEM_MISALIGN_ERR_EN in the reference model.
module tb_data_mem_responder;

  localparam int DEPTH_LOG2  = 10;
  localparam int WAIT_STATES = 3;
  localparam int MEM_BYTES   = 8 << DEPTH_LOG2;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic [63:0] req_addr = 64'd0;
  logic [63:0] req_wdata = 64'd0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [63:0] rsp_rdata;
  logic        rsp_err;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [7:0]  ref_bytes [0:MEM_BYTES-1];
  logic [63:0] exp_q[$];
  logic        err_q[$];

  data_mem_responder #(.DEPTH_LOG2(DEPTH_LOG2), .WAIT_STATES(WAIT_STATES)) dut (
    .CLK(CLK), .RESET(RESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .dbg_state(dbg_state)
  );

  // Clock and cycle counter
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: byte memory, little-endian, addresses wrap at MEM_BYTES.
  function automatic void model_access(input logic we, input logic [1:0] size,
                                       input logic [63:0] addr, input logic [63:0] wdata,
                                       output logic [63:0] rdata, output logic err);
    int nb;
    int base;
    logic mis;
    nb   = 1 << size;
    base = int'(addr % 64'(MEM_BYTES));
    mis  = (base % nb) != 0;
`ifdef DMEM_MISALIGN_ERR_EN
    err = mis;
`else
    err = 1'b0;
`endif
    base  = base - (base % nb);
    rdata = 64'd0;
    if (!err) begin
      for (int i = 0; i < nb; i++) begin
        if (we) ref_bytes[(base + i) % MEM_BYTES] = wdata[8*i +: 8];
        else    rdata = rdata | (64'(ref_bytes[(base + i) % MEM_BYTES]) << (8 * i));
      end
    end
  endfunction

  // Driver: one full transaction, with `hold` cycles of response back-pressure.
  task automatic do_txn(input logic we, input logic [1:0] size, input logic [63:0] addr,
                        input logic [63:0] wdata, input int hold);
    logic [63:0] exp_d;
    logic        exp_e;
    int n;
    int acc_cyc;
    @(negedge CLK);
    req_valid = 1'b1; req_we = we; req_size = size; req_addr = addr; req_wdata = wdata;
    rsp_ready = 1'b0;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge CLK); n++; end
    if (!req_ready) begin
      check_val("req_ready_timeout", 64'(req_ready), 64'd1);
      req_valid = 1'b0;
      return;
    end
    acc_cyc = cyc;
    model_access(we, size, addr, wdata, exp_d, exp_e);
    exp_q.push_back(exp_d);
    err_q.push_back(exp_e);
    @(negedge CLK);
    // Scramble request fields while busy; they must be ignored.
    req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom);
    req_addr = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};
    n = 0;
    while (!rsp_valid && n < 40) begin
      check_val("req_ready_busy", 64'(req_ready), 64'd0);
      @(negedge CLK); n++;
    end
    exp_d = exp_q.pop_front();
    exp_e = err_q.pop_front();
    if (!rsp_valid) begin
      check_val("rsp_valid_timeout", 64'(rsp_valid), 64'd1);
      return;
    end
    check_val("latency", 64'(cyc - acc_cyc), 64'(WAIT_STATES + 1));
    check_val("rsp_rdata", rsp_rdata, exp_d);
    check_val("rsp_err", 64'(rsp_err), 64'(exp_e));
    check_val("req_ready_resp", 64'(req_ready), 64'd0);
    for (int k = 0; k < hold; k++) begin
      @(negedge CLK);
      check_val("rsp_valid_hold", 64'(rsp_valid), 64'd1);
      check_val("rsp_rdata_hold", rsp_rdata, exp_d);
      check_val("rsp_err_hold", 64'(rsp_err), 64'(exp_e));
      check_val("req_ready_hold", 64'(req_ready), 64'd0);
    end
    rsp_ready = 1'b1;
    @(negedge CLK);
    rsp_ready = 1'b0;
    check_val("rsp_valid_after", 64'(rsp_valid), 64'd0);
    check_val("req_ready_after", 64'(req_ready), 64'd1);
  endtask

  // Check every output is quiet while reset is held.
  task automatic check_reset_outputs(input string tag);
    check_val({tag, "_req_ready"}, 64'(req_ready), 64'd0);
    check_val({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    check_val({tag, "_rsp_rdata"}, rsp_rdata, 64'd0);
    check_val({tag, "_rsp_err"}, 64'(rsp_err), 64'd0);
  endtask

  // Store accepted, then reset during WAIT: no response and no commit.
  task automatic do_abort_store(input logic [63:0] addr, input logic [63:0] wdata);
    int n;
    @(negedge CLK);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd3; req_addr = addr; req_wdata = wdata;
    n = 0;
    while (!req_ready && n < 50) begin @(negedge CLK); n++; end
    check_val("abort_accept", 64'(req_ready), 64'd1);
    @(negedge CLK);
    req_valid = 1'b0;
    @(negedge CLK);
    check_val("abort_in_wait_valid", 64'(rsp_valid), 64'd0);
    RESET = 1'b1;
    repeat (4) begin
      @(negedge CLK);
      check_reset_outputs("abort_rst");
    end
    RESET = 1'b0;
    @(negedge CLK);
    check_val("abort_ready_after", 64'(req_ready), 64'd1);
    check_val("abort_no_rsp", 64'(rsp_valid), 64'd0);
  endtask

  initial begin
    logic [63:0] a;
    for (int i = 0; i < MEM_BYTES; i++) ref_bytes[i] = 8'h00;

    // Reset
    repeat (3) begin
      @(negedge CLK);
      check_reset_outputs("reset");
    end
    RESET = 1'b0;
    @(negedge CLK);
    check_val("ready_after_reset", 64'(req_ready), 64'd1);

    // Initialise the working region (words 0..15) with doubleword stores.
    for (int w = 0; w < 16; w++) do_txn(1'b1, 2'd3, 64'(w * 8), {$urandom, $urandom}, 0);

    // Directed cases
    do_txn(1'b1, 2'd3, 64'h10, 64'h1122334455667788, 0);
    do_txn(1'b0, 2'd3, 64'h10, 64'd0, 0);
    do_txn(1'b1, 2'd0, 64'h13, 64'h00000000000000ab, 1);
    do_txn(1'b0, 2'd3, 64'h10, 64'd0, 4);
    do_txn(1'b0, 2'd0, 64'h13, 64'd0, 0);
    do_txn(1'b0, 2'd2, 64'h12, 64'd0, 0);
    do_txn(1'b1, 2'd1, 64'h11, 64'h000000000000beef, 0);
    do_txn(1'b0, 2'd3, 64'h10, 64'd0, 0);
    do_abort_store(64'h10, 64'hdeadbeefcafef00d);
    do_txn(1'b0, 2'd3, 64'h10, 64'd0, 0);
    do_txn(1'b1, 2'd3, 64'h2010, 64'h0badc0de12345678, 0);
    do_txn(1'b0, 2'd3, 64'h10, 64'd0, 2);

    // Randomized accesses inside the initialised region, with aliasing high bits.
    for (int t = 0; t < 120; t++) begin
      a = 64'($urandom_range(0, 127));
      if ($urandom_range(0, 3) == 0) a = a | ({$urandom, $urandom} << (DEPTH_LOG2 + 3));
      do_txn(1'($urandom), 2'($urandom_range(0, 3)), a, {$urandom, $urandom},
             int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
